// File: rtl/tpu_pkg.sv
// Shared TPU types and constants.
// Used by the TPU core and by its result drain stage.
package tpu_pkg;

    localparam int TPU_DATA_W = 8;

    typedef enum logic {
        PAYLOAD  = 1'b0,
        CHECKSUM = 1'b1
    } drain_state_t;

endpackage

// File: rtl/tpu_sync_fifo.sv
// Single-clock FIFO with extra pointer MSB for full/empty.
// Push and pop may coincide, including when full.
module tpu_sync_fifo #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       clr,
    input  logic                       push,
    input  logic [DATA_W-1:0]          din,
    input  logic                       pop,
    output logic [DATA_W-1:0]          head,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW:0]       wptr;
    logic [AW:0]       rptr;

    // Pointer update; clr drops all buffered entries.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (push) wptr <= wptr + 1'b1;
            if (pop)  rptr <= rptr + 1'b1;
        end
    end

    // Storage write; contents need no reset.
    always_ff @(posedge clk) begin
        if (push) mem[wptr[AW-1:0]] <= din;
    end

    assign count = wptr - rptr;
    assign full  = (count == CNT_FULL);
    assign empty = (wptr == rptr);
    assign head  = mem[rptr[AW-1:0]];

endmodule

// File: rtl/tpu_result_drain.sv
// Buffers TPU result bytes and re-emits them as framed packets
// of FRAME_LEN payload bytes plus one mod-2^DATA_W checksum byte.
module tpu_result_drain
    import tpu_pkg::*;
#(
    parameter int DATA_W       = TPU_DATA_W,
    parameter int DEPTH        = 8,
    parameter int FRAME_LEN    = 4,
    parameter int AFULL_MARGIN = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              tpu_done,
    input  logic [DATA_W-1:0] tpu_data,
    output logic              tpu_ready,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last,
    output logic              overflow,
    output logic [7:0]        frame_cnt
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] READY_LIM = (AW+1)'(DEPTH - AFULL_MARGIN);
    localparam logic [7:0]  IDX_LAST  = 8'(FRAME_LEN - 1);

    drain_state_t      state;
    drain_state_t      state_nx;
    logic [DATA_W-1:0] sum;
    logic [7:0]        idx;
    logic [DATA_W-1:0] head;
    logic [AW:0]       count;
    logic [AW:0]       count_nx;
    logic              full;
    logic              empty;
    logic              hs;
    logic              pop;
    logic              accept;
    logic              push;

    assign hs       = out_valid & out_ready;
    assign pop      = hs & (state == PAYLOAD) & ~flush;
    assign accept   = tpu_done & (~full | pop);
    assign push     = accept & ~flush;
    assign count_nx = count + (AW+1)'(push) - (AW+1)'(pop);

    tpu_sync_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .clr   (flush),
        .push  (push),
        .din   (tpu_data),
        .pop   (pop),
        .head  (head),
        .count (count),
        .full  (full),
        .empty (empty)
    );

    // State register; flush restarts framing like reset.
    always_ff @(posedge clk) begin
        if (rst || flush) state <= PAYLOAD;
        else              state <= state_nx;
    end

    // Move to CHECKSUM after the last payload byte of a frame leaves.
    always_comb begin
        state_nx = state;
        unique case (state)
            PAYLOAD:  if (pop && idx == IDX_LAST) state_nx = CHECKSUM;
            CHECKSUM: if (hs)                     state_nx = PAYLOAD;
            default:  state_nx = PAYLOAD;
        endcase
    end

    // Stream outputs; data is zero whenever nothing is offered.
    always_comb begin
        out_valid = 1'b0;
        out_data  = '0;
        out_last  = 1'b0;
        unique case (state)
            PAYLOAD: begin
                out_valid = ~empty;
                out_data  = empty ? '0 : head;
            end
            CHECKSUM: begin
                out_valid = 1'b1;
                out_data  = sum;
                out_last  = 1'b1;
            end
            default: ;
        endcase
    end

    // Checksum, frame index, counters, sticky overflow, throttle.
    always_ff @(posedge clk) begin
        if (rst) begin
            sum       <= '0;
            idx       <= '0;
            frame_cnt <= '0;
            overflow  <= 1'b0;
            tpu_ready <= 1'b0;
        end else if (flush) begin
            sum       <= '0;
            idx       <= '0;
            tpu_ready <= 1'b0;
        end else begin
            if (pop) begin
                sum <= sum + head;
                idx <= (idx == IDX_LAST) ? 8'd0 : idx + 8'd1;
            end
            if (state == CHECKSUM && hs) begin
                sum       <= '0;
                frame_cnt <= frame_cnt + 8'd1;
            end
            if (tpu_done && !accept) overflow <= 1'b1;
            tpu_ready <= (count_nx <= READY_LIM);
        end
    end

endmodule

// File: tb/tb_tpu_result_drain.sv
// Randomized and directed bench for tpu_result_drain.
// Reference model keeps the pending output stream as a queue.
module tb_tpu_result_drain;

    localparam int DEPTH = 8;
    localparam int FL    = 4;
    localparam int AM    = 2;

    typedef struct {
        logic [7:0] d;
        logic       l;
    } ent_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       tpu_done;
    logic [7:0] tpu_data;
    logic       tpu_ready;
    logic       flush;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic       out_last;
    logic       overflow;
    logic [7:0] frame_cnt;

    int checks = 0;
    int errors = 0;

    ent_t mstream[$];
    ent_t sb[$];
    int         pay;
    logic [7:0] psum;
    logic       mov;
    logic [7:0] mfc;
    logic       mready;
    int         npay;
    logic       pp;
    ent_t       e;
    ent_t       m;

    tpu_result_drain #(
        .DATA_W       (8),
        .DEPTH        (DEPTH),
        .FRAME_LEN    (FL),
        .AFULL_MARGIN (AM)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .tpu_done  (tpu_done),
        .tpu_data  (tpu_data),
        .tpu_ready (tpu_ready),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .overflow  (overflow),
        .frame_cnt (frame_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(string n, logic [31:0] act, logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", n, act, req);
        end
    endtask

    // Reference model: advances at each rising edge from the inputs.
    initial begin
        pay = 0; psum = 0; mov = 0; mfc = 0; mready = 0;
        forever begin
            @(posedge clk);
            if (rst) begin
                mstream.delete(); sb.delete();
                pay = 0; psum = 0; mov = 0; mfc = 0; mready = 0;
            end else if (flush) begin
                mstream.delete(); sb.delete();
                pay = 0; psum = 0; mready = 0;
            end else begin
                npay = 0;
                foreach (mstream[i]) if (!mstream[i].l) npay++;
                pp = 1'b0;
                if (out_ready && mstream.size() > 0) begin
                    m = mstream.pop_front();
                    if (m.l) mfc = mfc + 8'd1;
                    else     pp = 1'b1;
                end
                if (pp) npay--;
                if (tpu_done) begin
                    if (npay < DEPTH) begin
                        npay++;
                        m.d = tpu_data; m.l = 1'b0;
                        mstream.push_back(m); sb.push_back(m);
                        psum = psum + tpu_data;
                        pay++;
                        if (pay == FL) begin
                            m.d = psum; m.l = 1'b1;
                            mstream.push_back(m); sb.push_back(m);
                            pay = 0; psum = 0;
                        end
                    end else begin
                        mov = 1'b1;
                    end
                end
                mready = (npay <= DEPTH - AM);
            end
        end
    end

    // Monitor: compares status every cycle and each handshake byte.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst) begin
                chk("out_valid", out_valid, mstream.size() > 0);
                chk("tpu_ready", tpu_ready, mready);
                chk("overflow", overflow, mov);
                chk("frame_cnt", frame_cnt, mfc);
                if (out_valid && out_ready && !flush) begin
                    if (sb.size() == 0) begin
                        chk("sb_underrun", 1, 0);
                    end else begin
                        e = sb.pop_front();
                        chk("out_data", out_data, e.d);
                        chk("out_last", out_last, e.l);
                    end
                end
            end
        end
    end

    task automatic step(bit d, logic [7:0] v, bit r, bit f);
        tpu_done  = d;
        tpu_data  = v;
        out_ready = r;
        flush     = f;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(int n, bit r);
        for (int i = 0; i < n; i++) step(0, 8'h00, r, 0);
    endtask

    initial begin
        logic [7:0] seq [4];
        rst = 1'b1;
        tpu_done = 0; tpu_data = 0; out_ready = 0; flush = 0;
        idle(2, 0);
        chk("rst_valid", out_valid, 0);
        chk("rst_data", out_data, 0);
        chk("rst_last", out_last, 0);
        chk("rst_ready", tpu_ready, 0);
        chk("rst_ovf", overflow, 0);
        chk("rst_fcnt", frame_cnt, 0);
        rst = 1'b0;
        idle(2, 1);

        seq = '{8'h11, 8'h22, 8'h33, 8'h44};
        for (int i = 0; i < 4; i++) step(1, seq[i], 1, 0);
        idle(8, 1);
        chk("frame_one", frame_cnt, 1);

        for (int i = 0; i < 4; i++) step(1, 8'hFF, 1, 0);
        idle(8, 1);
        chk("frame_two", frame_cnt, 2);

        for (int i = 0; i < 8; i++) step(1, 8'(8'h80 + i), 0, 0);
        chk("full_no_ovf", overflow, 0);
        step(1, 8'h99, 0, 0);
        chk("ovf_set", overflow, 1);

        step(1, 8'h5A, 1, 0);
        idle(15, 1);

        step(1, 8'h10, 1, 0);
        step(1, 8'h20, 1, 0);
        idle(1, 1);
        step(0, 8'h00, 1, 1);
        chk("flush_valid", out_valid, 0);
        for (int i = 0; i < 4; i++) step(1, 8'(8'h31 + i), 1, 0);
        idle(8, 1);

        for (int i = 0; i < 4; i++) step(1, 8'(i + 1), 0, 0);
        idle(4, 1);
        for (int i = 0; i < 5; i++) begin
            if (i < 3) step(1, 8'(8'h41 + i), 0, 0);
            else       step(0, 8'h00, 0, 0);
            chk("hold_data", out_data, 8'h0A);
            chk("hold_last", out_last, 1);
        end
        idle(10, 1);

        for (int c = 0; c < 3000; c++) begin
            rst = ($urandom_range(0, 599) == 0);
            step(tpu_ready ? ($urandom_range(0, 3) != 0)
                           : ($urandom_range(0, 7) == 0),
                 8'($urandom),
                 $urandom_range(0, 3) != 0,
                 $urandom_range(0, 149) == 0);
        end
        rst = 1'b0;
        idle(40, 1);
        chk("sb_drained", sb.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
